// File: rtl/reg_file.sv
// reg_file: sixteen DW-bit registers with two registered read operands, one write-back
// port and a merged ALU flag path into R[FLAG_REG]. Define REG_FILE_BYPASS_EN for write-to-read bypass.
module reg_file #(
  parameter int DW       = 8,
  parameter int AW       = 4,
  parameter int FLAG_REG = 12
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic [AW-1:0] RaddrA,
  input  logic [AW-1:0] RaddrB,
  input  logic          ReadEn,
  output logic [DW-1:0] DataOutA,
  output logic [DW-1:0] DataOutB,
  input  logic          WriteEn,
  input  logic [AW-1:0] Waddr,
  input  logic [DW-1:0] DataIn,
  input  logic          FlagEn,
  input  logic          ZeroIn,
  input  logic          OverflowIn,
  output logic [DW-1:0] FlagsOut
);

  localparam int NREG = 1 << AW;

  logic [DW-1:0] regs     [NREG];
  logic [DW-1:0] reg_next [NREG];
  logic [DW-1:0] rd_src   [NREG];
  logic          wr_hit;

  assign wr_hit = WriteEn && (Waddr != '0);

  // Post-write image of the whole file: general write first, then the flag bits
  // overlay it so they win when both target FLAG_REG in the same cycle.
  // NOTE: each entry gets its default assignment first, so no latch is inferred.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      reg_next[i] = regs[i];
      if (wr_hit && (Waddr == AW'(i))) reg_next[i] = DataIn;
    end
    reg_next[0] = '0;
    if (FlagEn) reg_next[FLAG_REG][1:0] = {OverflowIn, ZeroIn};
  end

`ifdef REG_FILE_BYPASS_EN
  // Operands captured in a write cycle see the value being written.
  always_comb begin
    for (int i = 0; i < NREG; i++) rd_src[i] = reg_next[i];
  end
`else
  // Operands captured in a write cycle see the value from before the write.
  always_comb begin
    for (int i = 0; i < NREG; i++) rd_src[i] = regs[i];
  end
`endif

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  // NOTE: the storage array is reset too, because every register must read 0 after Reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      DataOutA <= '0;
      DataOutB <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) regs[i] <= reg_next[i];
      if (ReadEn) begin
        DataOutA <= rd_src[RaddrA];
        DataOutB <= rd_src[RaddrB];
      end
    end
  end

  assign FlagsOut = regs[FLAG_REG];

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed scenarios plus randomized traffic checked against an
// array-based model of the register file rules.
module tb_reg_file;
  localparam int DW = 8, AW = 4, FLAG_REG = 12, NREG = 16;

  logic          Clk = 1'b0;
  logic          Reset, ReadEn, WriteEn, FlagEn, ZeroIn, OverflowIn;
  logic [AW-1:0] RaddrA, RaddrB, Waddr;
  logic [DW-1:0] DataIn, DataOutA, DataOutB, FlagsOut;

  reg_file #(.DW(DW), .AW(AW), .FLAG_REG(FLAG_REG)) dut (
    .Clk(Clk), .Reset(Reset), .RaddrA(RaddrA), .RaddrB(RaddrB), .ReadEn(ReadEn),
    .DataOutA(DataOutA), .DataOutB(DataOutB), .WriteEn(WriteEn), .Waddr(Waddr),
    .DataIn(DataIn), .FlagEn(FlagEn), .ZeroIn(ZeroIn), .OverflowIn(OverflowIn),
    .FlagsOut(FlagsOut)
  );

  always #5 Clk = ~Clk;

  int tests_run = 0;
  int tests_failed = 0;

  logic [DW-1:0] model [NREG];
  logic [DW-1:0] exp_a = '0;
  logic [DW-1:0] exp_b = '0;

  task automatic idle();
    Reset = 0; ReadEn = 0; WriteEn = 0; FlagEn = 0; ZeroIn = 0; OverflowIn = 0;
    RaddrA = '0; RaddrB = '0; Waddr = '0; DataIn = '0;
  endtask

  // One clock edge; the model applies the register-file rules to the inputs driven before it.
  task automatic tick();
    logic [DW-1:0] after [NREG];
    @(posedge Clk);
    if (Reset) begin
      for (int i = 0; i < NREG; i++) model[i] = '0;
      exp_a = '0;
      exp_b = '0;
    end else begin
      after = model;
      if (WriteEn && Waddr != 0) after[Waddr] = DataIn;
      if (FlagEn) begin
        after[FLAG_REG][0] = ZeroIn;
        after[FLAG_REG][1] = OverflowIn;
      end
      if (ReadEn) begin
`ifdef REG_FILE_BYPASS_EN
        exp_a = after[RaddrA];
        exp_b = after[RaddrB];
`else
        exp_a = model[RaddrA];
        exp_b = model[RaddrB];
`endif
      end
      model = after;
    end
    @(negedge Clk);
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    WriteEn = 1; Waddr = a; DataIn = d;
    tick();
    idle();
  endtask

  task automatic read(input logic [AW-1:0] a, input logic [AW-1:0] b);
    ReadEn = 1; RaddrA = a; RaddrB = b;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    Reset = 1;
    tick();
    idle();
    tests_run++;
    if (DataOutA !== 8'h00 || DataOutB !== 8'h00 || FlagsOut !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_initial: got A=%02h B=%02h F=%02h expected 00/00/00", DataOutA, DataOutB, FlagsOut);
    end
    write(4'd5, 8'hAA);
    WriteEn = 1; Waddr = 4'd12; DataIn = 8'h77; FlagEn = 1; ZeroIn = 1; ReadEn = 1; RaddrA = 4'd5;
    Reset = 1;
    tick();
    idle();
    read(4'd5, 4'd12);
    tests_run++;
    if (DataOutA !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_r5: got %02h expected 00", DataOutA);
    end
    tests_run++;
    if (DataOutB !== 8'h00 || FlagsOut !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_flags: got B=%02h F=%02h expected 00/00", DataOutB, FlagsOut);
    end
    write(4'd5, 8'h3C);
    read(4'd5, 4'd0);
    tests_run++;
    if (DataOutA !== 8'h3C) begin
      tests_failed++;
      $display("FAIL reset_first_write: got %02h expected 3c", DataOutA);
    end
  endtask

  task automatic test_write_read();
    write(4'd3, 8'h5C);
    write(4'd7, 8'h13);
    read(4'd3, 4'd7);
    tests_run++;
    if (DataOutA !== 8'h5C) begin
      tests_failed++;
      $display("FAIL write_read_a: got %02h expected 5c", DataOutA);
    end
    tests_run++;
    if (DataOutB !== 8'h13) begin
      tests_failed++;
      $display("FAIL write_read_b: got %02h expected 13", DataOutB);
    end
  endtask

  task automatic test_r0();
    write(4'd0, 8'hFF);
    read(4'd0, 4'd0);
    tests_run++;
    if (DataOutA !== 8'h00 || DataOutB !== 8'h00) begin
      tests_failed++;
      $display("FAIL r0_zero: got A=%02h B=%02h expected 00/00", DataOutA, DataOutB);
    end
  endtask

  task automatic test_flag_merge();
    WriteEn = 1; Waddr = 4'd12; DataIn = 8'hF0; FlagEn = 1; ZeroIn = 1; OverflowIn = 0;
    tick();
    idle();
    tests_run++;
    if (FlagsOut !== 8'hF1) begin
      tests_failed++;
      $display("FAIL flag_merge: got %02h expected f1", FlagsOut);
    end
    FlagEn = 1; ZeroIn = 0; OverflowIn = 1;
    tick();
    idle();
    tests_run++;
    if (FlagsOut !== 8'hF2) begin
      tests_failed++;
      $display("FAIL flag_only: got %02h expected f2", FlagsOut);
    end
    WriteEn = 1; Waddr = 4'd12; DataIn = 8'h0F; FlagEn = 1; ZeroIn = 0; OverflowIn = 0;
    tick();
    idle();
    tests_run++;
    if (FlagsOut !== 8'h0C) begin
      tests_failed++;
      $display("FAIL flag_priority: got %02h expected 0c", FlagsOut);
    end
  endtask

  task automatic test_collision();
    logic [DW-1:0] want;
    write(4'd4, 8'h11);
    WriteEn = 1; Waddr = 4'd4; DataIn = 8'h22; ReadEn = 1; RaddrA = 4'd4; RaddrB = 4'd0;
    tick();
    idle();
`ifdef REG_FILE_BYPASS_EN
    want = 8'h22;
`else
    want = 8'h11;
`endif
    tests_run++;
    if (DataOutA !== want) begin
      tests_failed++;
      $display("FAIL collision_gen: got %02h expected %02h", DataOutA, want);
    end
    read(4'd4, 4'd4);
    tests_run++;
    if (DataOutA !== 8'h22 || DataOutB !== 8'h22) begin
      tests_failed++;
      $display("FAIL collision_after: got A=%02h B=%02h expected 22/22", DataOutA, DataOutB);
    end
    // R12 holds 0x0C here; a flag-only update collides with a read of R12.
    FlagEn = 1; ZeroIn = 1; OverflowIn = 1; ReadEn = 1; RaddrA = 4'd2; RaddrB = 4'd12;
    tick();
    idle();
`ifdef REG_FILE_BYPASS_EN
    want = 8'h0F;
`else
    want = 8'h0C;
`endif
    tests_run++;
    if (DataOutB !== want) begin
      tests_failed++;
      $display("FAIL collision_flag: got %02h expected %02h", DataOutB, want);
    end
  endtask

  task automatic test_hold();
    write(4'd2, 8'h01);
    read(4'd2, 4'd2);
    write(4'd2, 8'h02);
    RaddrA = 4'd3; RaddrB = 4'd7;
    tick();
    idle();
    tests_run++;
    if (DataOutA !== 8'h01 || DataOutB !== 8'h01) begin
      tests_failed++;
      $display("FAIL hold: got A=%02h B=%02h expected 01/01", DataOutA, DataOutB);
    end
    read(4'd2, 4'd0);
    tests_run++;
    if (DataOutA !== 8'h02) begin
      tests_failed++;
      $display("FAIL hold_release: got %02h expected 02", DataOutA);
    end
  endtask

  task automatic test_back_to_back();
    write(4'd9, 8'hA1);
    write(4'd9, 8'hB2);
    write(4'd9, 8'hC3);
    read(4'd9, 4'd9);
    tests_run++;
    if (DataOutA !== 8'hC3 || DataOutB !== 8'hC3) begin
      tests_failed++;
      $display("FAIL back_to_back: got A=%02h B=%02h expected c3/c3", DataOutA, DataOutB);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      Reset      = ($urandom_range(0, 59) == 0);
      ReadEn     = $urandom_range(0, 1);
      WriteEn    = ($urandom_range(0, 3) != 0);
      FlagEn     = ($urandom_range(0, 2) == 0);
      ZeroIn     = $urandom_range(0, 1);
      OverflowIn = $urandom_range(0, 1);
      Waddr      = AW'($urandom_range(0, NREG - 1));
      RaddrA     = ($urandom_range(0, 3) == 0) ? Waddr : AW'($urandom_range(0, NREG - 1));
      RaddrB     = ($urandom_range(0, 3) == 0) ? AW'(FLAG_REG) : AW'($urandom_range(0, NREG - 1));
      DataIn     = DW'($urandom);
      tick();
      tests_run++;
      if (DataOutA !== exp_a || DataOutB !== exp_b || FlagsOut !== model[FLAG_REG]) begin
        tests_failed++;
        $display("FAIL random_%0d: got A=%02h B=%02h F=%02h expected %02h/%02h/%02h",
                 n, DataOutA, DataOutB, FlagsOut, exp_a, exp_b, model[FLAG_REG]);
      end
    end
    idle();
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) model[i] = '0;
    idle();
    test_reset();
    test_write_read();
    test_r0();
    test_flag_merge();
    test_collision();
    test_hold();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
